wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RV32I core: the producer side of the register file write port. It accepts one retiring instruction at a time from the memory stage, waits for load data where required, and forms the 32-bit result: ALU value, sign/zero-extended load data, or PC+4 for JAL/JALR. It then drives the register file's `reg_wr_en` / `write_data` / destination for exactly one cycle. It also optionally exposes the committing value for operand forwarding.

## Interface
Parameters: none.

Ports. Clocking and reset are one clock, `clock`; reset is `resetn`, asynchronous, active-low.
- `clock`  in  1  core clock; all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  memory stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_rd`  in  5  destination register index
- `in_wb_sel`  in  2  result source:
  - 0 = ALU
  - 1 = LOAD
  - 2 = PC+4
  - 3 = none (store/branch)
- `in_funct3`  in  3  load width/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- `in_addr_lo`  in  2  load byte address bits [1:0]
- `in_alu_result`  in  32  ALU result
- `in_pc`  in  32  instruction PC
- `dmem_rvalid`  in  1  data memory read data valid
- `dmem_rdata`  in  32  data memory read word (little-endian)
- `reg_wr_en`  out  1  register file write enable
- `reg_wr_addr`  out  5  register file write index
- `write_data`  out  32  register file write data
- `retire`  out  1  one-cycle pulse per completed instruction
- `load_fault`  out  1  one-cycle pulse, misaligned/illegal load
- `fwd_valid`  out  1  forwarding value valid
- `fwd_rd`  out  5  forwarding register index
- `fwd_data`  out  32  forwarding value

## Operation
- States:
  - IDLE: `in_ready`=1.
  - WAIT_LOAD: `in_ready`=0.
  - COMMIT: `in_ready`=1.
- Transfer occurs when `in_valid && in_ready` at a rising edge; all `in_*` fields are captured into holding registers.
- IDLE/COMMIT with transfer:
  - `in_wb_sel`=1 → WAIT_LOAD.
  - Any other value → COMMIT.
- IDLE/COMMIT without transfer → IDLE.
- WAIT_LOAD: on `dmem_rvalid`=1, capture `dmem_rdata` → COMMIT; otherwise stay, indefinitely.
- `dmem_rvalid` is ignored in IDLE and COMMIT.
- COMMIT (one cycle): `retire`=1.
  - `reg_wr_en`=1 iff captured sel∈{0,1,2}, rd≠0, and no fault.
  - `reg_wr_addr` = captured rd.
- Result formation:
  - sel0: the ALU value.
  - sel2: `in_pc`+4, modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - sel3: 0 and no write.
- Load extraction (sel1): the word is shifted right by 8×addr_lo.
  - LB/LBU: byte [7:0], sign- or zero-extended.
  - LH/LHU: half [15:0], sign- or zero-extended.
  - LW: whole word.
- Fault cases:
  - LH/LHU with addr_lo[0]=1.
  - LW with addr_lo≠0.
  - funct3 ∈ {3,6,7}.
  - Effect: `load_fault`=1 and `retire`=1 in COMMIT, `reg_wr_en`=0, `write_data`=0.
- In COMMIT, `write_data` holds the final result; outside COMMIT, `write_data` and `reg_wr_addr` are 0.

## Timing
- Reset: state IDLE; every output is 0, except `in_ready`=1 after reset is released (it is combinational from state).
- Latency, acceptance edge to `reg_wr_en`:
  - non-load: 1 cycle.
  - load: 1 cycle after the edge that sees `dmem_rvalid`.
- Back-to-back non-load instructions sustain one retirement per cycle, because COMMIT accepts.
- Reset mid-WAIT_LOAD abandons the load. A late `dmem_rvalid` after reset causes no write.
- `in_ready` depends only on state, never on `in_valid`.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_valid` = `reg_wr_en`.
  - `fwd_rd` = `reg_wr_addr`.
  - `fwd_data` = `write_data` (same cycle).
- `WB_FORWARD_EN` undefined: `fwd_valid`, `fwd_rd` and `fwd_data` are tied to 0. The ports remain present.

## Test plan
- ALU, rd=5, result 0x12345678, accepted at edge N → `reg_wr_en`=1, addr 5, data 0x12345678 in cycle N+1, `retire`=1.
- LB, addr_lo=3, dmem_rdata 0x80FFFFFF, rvalid 4 cycles late → `in_ready`=0 while waiting; data 0xFFFFFF80. LBU with the same inputs → 0x00000080.
- LW with addr_lo=2 → `load_fault`=1, `retire`=1, `reg_wr_en`=0. funct3=3 → same response.
- PC+4 with pc=0xFFFFFFFC, rd=1 → data 0x00000000. Any sel with rd=0 → `reg_wr_en`=0, `retire`=1.
- Three back-to-back ALU instructions → three consecutive write cycles.
- Reset asserted in WAIT_LOAD, then rvalid after release → no write, all outputs 0.
- With `WB_FORWARD_EN`, fwd mirrors the write port; without it, fwd stays 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction, waits for load data, forms the result
// and drives the register file write port for one cycle. WB_FORWARD_EN exposes it for forwarding.
module wb_stage (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] write_data,
  output logic        retire,
  output logic        load_fault,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  typedef enum logic [1:0] {StIdle, StWaitLoad, StCommit} state_t;

  localparam logic [1:0] SelAlu  = 2'd0;
  localparam logic [1:0] SelLoad = 2'd1;
  localparam logic [1:0] SelPc4  = 2'd2;

  state_t      state_q, state_d;
  logic [4:0]  rd_q;
  logic [1:0]  sel_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic [31:0] word_q;

  logic        accept;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        fault;
  logic [31:0] result;

  assign in_ready = (state_q != StWaitLoad);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (!accept)                  state_d = StIdle;
        else if (in_wb_sel == SelLoad) state_d = StWaitLoad;
        else                          state_d = StCommit;
      end
      StWaitLoad: if (dmem_rvalid) state_d = StCommit;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      sel_q     <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      pc_q      <= '0;
      word_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q      <= in_rd;
        sel_q     <= in_wb_sel;
        funct3_q  <= in_funct3;
        addr_lo_q <= in_addr_lo;
        alu_q     <= in_alu_result;
        pc_q      <= in_pc;
      end
      if (state_q == StWaitLoad && dmem_rvalid) word_q <= dmem_rdata;
    end
  end

  // Little-endian: the addressed byte lands in bits [7:0] after the shift.
  assign shifted = word_q >> {addr_lo_q, 3'b000};

  always_comb begin
    load_val = '0;
    fault    = 1'b0;
    unique case (funct3_q)
      3'd0: load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd4: load_val = {24'd0, shifted[7:0]};
      3'd1: begin
        load_val = {{16{shifted[15]}}, shifted[15:0]};
        fault    = addr_lo_q[0];
      end
      3'd5: begin
        load_val = {16'd0, shifted[15:0]};
        fault    = addr_lo_q[0];
      end
      3'd2: begin
        load_val = shifted;
        fault    = (addr_lo_q != 2'd0);
      end
      default: fault = 1'b1;
    endcase
    if (sel_q != SelLoad) fault = 1'b0;
  end

  always_comb begin
    result = '0;
    unique case (sel_q)
      SelAlu:  result = alu_q;
      SelLoad: result = fault ? 32'd0 : load_val;
      SelPc4:  result = pc_q + 32'd4;
      default: result = '0;
    endcase
  end

  always_comb begin
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    write_data  = '0;
    retire      = 1'b0;
    load_fault  = 1'b0;
    if (state_q == StCommit) begin
      retire      = 1'b1;
      load_fault  = fault;
      reg_wr_addr = rd_q;
      write_data  = result;
      reg_wr_en   = (sel_q != 2'd3) && (rd_q != 5'd0) && !fault;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid = reg_wr_en;
  assign fwd_rd    = reg_wr_addr;
  assign fwd_data  = write_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan steps then randomized transactions checked against an
// arithmetic reference model of the result/fault rules.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] write_data;
  logic        retire;
  logic        load_fault;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int vectors = 0;
  int errors  = 0;

  wb_stage dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .write_data(write_data), .retire(retire), .load_fault(load_fault),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble_inputs();
    in_rd         = 5'($urandom);
    in_wb_sel     = 2'($urandom);
    in_funct3     = 3'($urandom);
    in_addr_lo    = 2'($urandom);
    in_alu_result = $urandom;
    in_pc         = $urandom;
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, ".in_ready"}, in_ready, exp_ready);
    check({tag, ".reg_wr_en"}, reg_wr_en, 0);
    check({tag, ".reg_wr_addr"}, reg_wr_addr, 0);
    check({tag, ".write_data"}, write_data, 0);
    check({tag, ".retire"}, retire, 0);
    check({tag, ".load_fault"}, load_fault, 0);
    check({tag, ".fwd_valid"}, fwd_valid, 0);
    check({tag, ".fwd_rd"}, fwd_rd, 0);
    check({tag, ".fwd_data"}, fwd_data, 0);
  endtask

  // Reference model: result and fault from the architectural load/writeback rules.
  function automatic void model(input logic [1:0] sel, input logic [2:0] f3,
                                input logic [1:0] alo, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [31:0] word,
                                output logic fault, output logic [31:0] data);
    longint size, v, span;
    bit     is_signed;
    fault = 1'b0;
    data  = 32'd0;
    case (sel)
      2'd0: data = alu;
      2'd2: data = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
      2'd1: begin
        size      = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
        is_signed = (f3 == 0 || f3 == 1);
        fault     = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (int'(alo) % size != 0);
        if (!fault) begin
          span = longint'(1) << (8 * size);
          v    = (longint'(word) / (longint'(1) << (8 * int'(alo)))) % span;
          if (is_signed && size < 4 && v >= span / 2) v = v - span;
          data = 32'(v);
        end
      end
      default: data = 32'd0;
    endcase
  endfunction

  task automatic check_commit(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [1:0] alo,
                              input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] word);
    logic        fault;
    logic [31:0] data;
    logic        wen;
    model(sel, f3, alo, alu, pc, word, fault, data);
    wen = (sel != 2'd3) && (rd != 5'd0) && !fault;
    check({tag, ".retire"}, retire, 1);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".reg_wr_en"}, reg_wr_en, wen);
    check({tag, ".reg_wr_addr"}, reg_wr_addr, rd);
    check({tag, ".write_data"}, write_data, data);
    check({tag, ".load_fault"}, load_fault, fault);
`ifdef WB_FORWARD_EN
    check({tag, ".fwd_valid"}, fwd_valid, wen);
    check({tag, ".fwd_rd"}, fwd_rd, rd);
    check({tag, ".fwd_data"}, fwd_data, data);
`else
    check({tag, ".fwd_valid"}, fwd_valid, 0);
    check({tag, ".fwd_rd"}, fwd_rd, 0);
    check({tag, ".fwd_data"}, fwd_data, 0);
`endif
  endtask

  // Presents one instruction in a cycle where in_ready is expected; ends in its COMMIT cycle.
  task automatic issue(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] word, input int lat);
    check({tag, ".ready_before"}, in_ready, 1);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_addr_lo    = alo;
    in_alu_result = alu;
    in_pc         = pc;
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    if (sel == 2'd1) begin
      for (int i = 0; i < lat; i++) begin
        check_quiet({tag, ".wait"}, 1'b0);
        in_valid   = 1'($urandom);
        dmem_rdata = $urandom;
        tick();
      end
      check_quiet({tag, ".wait"}, 1'b0);
      in_valid    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = word;
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
    end
    check_commit(tag, rd, sel, f3, alo, alu, pc, word);
  endtask

  task automatic idle_tick(input string tag);
    in_valid    = 1'b0;
    dmem_rvalid = 1'($urandom);
    dmem_rdata  = $urandom;
    tick();
    dmem_rvalid = 1'b0;
    check_quiet(tag, 1'b1);
  endtask

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    in_rd = '0; in_wb_sel = '0; in_funct3 = '0; in_addr_lo = '0;
    in_alu_result = '0; in_pc = '0;
    #1;
    check("rst.reg_wr_en", reg_wr_en, 0);
    check("rst.write_data", write_data, 0);
    check("rst.retire", retire, 0);
    check("rst.load_fault", load_fault, 0);
    tick();
    tick();
    resetn = 1'b1;
    check_quiet("post_rst", 1'b1);

    issue("alu_rd5", 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
    idle_tick("after_alu");
    issue("lb_late", 5'd7, 2'd1, 3'd0, 2'd3, 32'h0, 32'h0, 32'h80FF_FFFF, 4);
    check("lb_late.value", write_data, 32'hFFFF_FF80);
    issue("lbu_late", 5'd7, 2'd1, 3'd4, 2'd3, 32'h0, 32'h0, 32'h80FF_FFFF, 4);
    check("lbu_late.value", write_data, 32'h0000_0080);
    issue("lw_misalign", 5'd9, 2'd1, 3'd2, 2'd2, 32'h0, 32'h0, 32'hDEAD_BEEF, 1);
    check("lw_misalign.fault", load_fault, 1);
    issue("funct3_3", 5'd9, 2'd1, 3'd3, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    check("funct3_3.fault", load_fault, 1);
    issue("pc4_wrap", 5'd1, 2'd2, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);
    check("pc4_wrap.value", write_data, 32'h0);
    issue("rd0_alu", 5'd0, 2'd0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 0);
    issue("rd0_pc4", 5'd0, 2'd2, 3'd0, 2'd0, 32'h0, 32'h100, 32'h0, 0);
    issue("sel3", 5'd4, 2'd3, 3'd0, 2'd0, 32'h1111_1111, 32'h200, 32'h0, 0);
    idle_tick("after_directed");

    // Back-to-back: each COMMIT cycle also accepts the next instruction.
    issue("b2b0", 5'd10, 2'd0, 3'd0, 2'd0, 32'hA0A0_0001, 32'h0, 32'h0, 0);
    issue("b2b1", 5'd11, 2'd0, 3'd0, 2'd0, 32'hA0A0_0002, 32'h0, 32'h0, 0);
    issue("b2b2", 5'd12, 2'd0, 3'd0, 2'd0, 32'hA0A0_0003, 32'h0, 32'h0, 0);
    idle_tick("after_b2b");

    // Reset while waiting for load data; late rvalid must not write.
    in_valid = 1'b1; in_rd = 5'd3; in_wb_sel = 2'd1; in_funct3 = 3'd2; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0;
    check("rst_wait.in_ready", in_ready, 0);
    resetn = 1'b0;
    #1;
    check("rst_wait.reg_wr_en", reg_wr_en, 0);
    check("rst_wait.retire", retire, 0);
    tick();
    resetn      = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    check_quiet("late_rvalid", 1'b1);
    idle_tick("late_rvalid2");

    for (int n = 0; n < 40; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      issue("rand", rd, 2'($urandom), 3'($urandom), 2'($urandom), $urandom,
            ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom,
            int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle_tick("rand_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
